// File: rtl/csi_param_pkg.sv
// csi_param_pkg: CSI-2 packet constants, FSM states and the CRC-16 step
// shared by the packet builder and its bench.
package csi_param_pkg;

  localparam logic [5:0] FRAME_START_DATA_TYPE = 6'h00;
  localparam logic [5:0] FRAME_END_DATA_TYPE   = 6'h01;
  localparam logic [5:0] PIXEL14BITS_DATA_TYPE = 6'h2D;
  localparam logic [7:0] ECC                   = 8'hCC;

  localparam int unsigned LONG_PACKET_FOOTER_WIDTH_BYTES = 2;
  localparam int unsigned SHORT_PACKET_WIDTH_BYTES       = 4;

  typedef enum logic [2:0] {
    IDLE,
    FS,
    LP_HDR,
    PAYLOAD_IN,
    PAYLOAD_OUT,
    FOOTER,
    FE
  } csi_pkt_state_t;

  // One byte of CRC-16, LSB first, reflected polynomial, no final XOR.
  function automatic logic [15:0] csi_crc16_byte(
    input logic [15:0] crc,
    input logic [7:0]  data
  );
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'h8408;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/csi_crc16.sv
// csi_crc16: registered byte-wide CRC-16, seed 0xFFFF on init.
// Built only when CSI_PKT_CRC_EN is defined.
`ifdef CSI_PKT_CRC_EN
module csi_crc16
  import csi_param_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init)    crc_d = 16'hFFFF;
    else if (en) crc_d = csi_crc16_byte(crc_q, data);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= 16'hFFFF;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule
`endif

// File: rtl/csi_packet_builder.sv
// csi_packet_builder: 14-bit pixel stream to CSI-2 RAW14 byte stream.
// Define CSI_PKT_CRC_EN for a computed CRC footer; otherwise it is 00 00.
module csi_packet_builder
  import csi_param_pkg::*;
#(
  parameter int unsigned LINE_PIXELS = 16,
  parameter logic [1:0]  VC          = 2'h0,
  parameter logic [5:0]  DT          = PIXEL14BITS_DATA_TYPE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [13:0] pix_data,
  input  logic        pix_sof,
  input  logic        pix_eol,
  input  logic        pix_eof,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        byte_sop,
  output logic        byte_eop,
  output logic        line_err
);

  localparam int unsigned   CW       = $clog2(LINE_PIXELS + 1);
  localparam logic [15:0]   WC       = 16'(LINE_PIXELS * 7 / 4);
  localparam logic [2:0]    SP_LAST  = 3'(SHORT_PACKET_WIDTH_BYTES - 1);
  localparam logic [2:0]    FT_LAST  = 3'(LONG_PACKET_FOOTER_WIDTH_BYTES - 1);
  localparam logic [CW-1:0] PIX_LAST = CW'(LINE_PIXELS - 1);
  localparam logic [CW-1:0] PIX_END  = CW'(LINE_PIXELS);

  csi_pkt_state_t   state_q, state_d;
  logic [2:0]       b_cnt_q, b_cnt_d;
  logic [1:0]       g_cnt_q, g_cnt_d;
  logic [CW-1:0]    pix_cnt_q, pix_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             eof_q, eof_d;
  logic [3:0][13:0] grp_q, grp_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             byte_sop_q, byte_sop_d;
  logic             byte_eop_q, byte_eop_d;
  logic             line_err_q, line_err_d;
  logic             pix_ready_q, pix_ready_d;

  logic        can_load, emit, load, accept;
  logic        osop, oeop;
  logic [7:0]  ob;
  logic [15:0] crc;

  function automatic logic [7:0] sp_byte(
    input logic [2:0]  idx,
    input logic [5:0]  dt,
    input logic [15:0] fc
  );
    logic [7:0] r;
    unique case (idx)
      3'd0:    r = {VC, dt};
      3'd1:    r = fc[7:0];
      3'd2:    r = fc[15:8];
      default: r = ECC;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    b_cnt_d     = b_cnt_q;
    g_cnt_d     = g_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    frame_cnt_d = frame_cnt_q;
    eof_d       = eof_q;
    grp_d       = grp_q;
    line_err_d  = 1'b0;
    emit        = 1'b0;
    ob          = 8'h00;
    osop        = 1'b0;
    oeop        = 1'b0;
    can_load    = !byte_valid_q || byte_ready;
    accept      = pix_valid && pix_ready_q;

    unique case (state_q)
      IDLE: begin
        if (pix_valid && !pix_sof) begin
          state_d = LP_HDR;
          b_cnt_d = 3'd0;
        end else if (pix_valid && can_load) begin
          // FS byte 0 leaves straight from IDLE for one-cycle latency
          emit    = 1'b1;
          osop    = 1'b1;
          ob      = sp_byte(3'd0, FRAME_START_DATA_TYPE, frame_cnt_q);
          state_d = FS;
          b_cnt_d = 3'd1;
        end
      end
      FS: begin
        if (can_load) begin
          emit    = 1'b1;
          ob      = sp_byte(b_cnt_q, FRAME_START_DATA_TYPE, frame_cnt_q);
          oeop    = (b_cnt_q == SP_LAST);
          b_cnt_d = b_cnt_q + 3'd1;
          if (oeop) begin
            state_d = LP_HDR;
            b_cnt_d = 3'd0;
          end
        end
      end
      LP_HDR: begin
        if (can_load) begin
          emit = 1'b1;
          osop = (b_cnt_q == 3'd0);
          unique case (b_cnt_q)
            3'd0:    ob = {VC, DT};
            3'd1:    ob = WC[7:0];
            3'd2:    ob = WC[15:8];
            default: ob = ECC;
          endcase
          b_cnt_d = b_cnt_q + 3'd1;
          if (b_cnt_q == SP_LAST) begin
            state_d = PAYLOAD_IN;
            b_cnt_d = 3'd0;
            g_cnt_d = 2'd0;
          end
        end
      end
      PAYLOAD_IN: begin
        if (accept) begin
          grp_d[g_cnt_q] = pix_data;
          pix_cnt_d      = pix_cnt_q + CW'(1);
          line_err_d     = pix_eol ^ (pix_cnt_q == PIX_LAST);
          if (pix_cnt_q == PIX_LAST) eof_d = pix_eof && pix_eol;
          g_cnt_d = g_cnt_q + 2'd1;
          if (g_cnt_q == 2'd3) begin
            state_d = PAYLOAD_OUT;
            b_cnt_d = 3'd0;
          end
        end
      end
      PAYLOAD_OUT: begin
        if (can_load) begin
          emit = 1'b1;
          unique case (b_cnt_q)
            3'd0:    ob = grp_q[0][13:6];
            3'd1:    ob = grp_q[1][13:6];
            3'd2:    ob = grp_q[2][13:6];
            3'd3:    ob = grp_q[3][13:6];
            3'd4:    ob = {grp_q[1][1:0], grp_q[0][5:0]};
            3'd5:    ob = {grp_q[2][3:0], grp_q[1][5:2]};
            default: ob = {grp_q[3][5:0], grp_q[2][5:4]};
          endcase
          b_cnt_d = b_cnt_q + 3'd1;
          if (b_cnt_q == 3'd6) begin
            b_cnt_d = 3'd0;
            g_cnt_d = 2'd0;
            state_d = (pix_cnt_q == PIX_END) ? FOOTER : PAYLOAD_IN;
          end
        end
      end
      FOOTER: begin
        if (can_load) begin
          emit    = 1'b1;
          ob      = (b_cnt_q == 3'd0) ? crc[7:0] : crc[15:8];
          oeop    = (b_cnt_q == FT_LAST);
          b_cnt_d = b_cnt_q + 3'd1;
          if (oeop) begin
            b_cnt_d   = 3'd0;
            pix_cnt_d = '0;
            state_d   = eof_q ? FE : IDLE;
          end
        end
      end
      FE: begin
        if (can_load) begin
          emit    = 1'b1;
          ob      = sp_byte(b_cnt_q, FRAME_END_DATA_TYPE, frame_cnt_q);
          osop    = (b_cnt_q == 3'd0);
          oeop    = (b_cnt_q == SP_LAST);
          b_cnt_d = b_cnt_q + 3'd1;
          if (oeop) begin
            b_cnt_d     = 3'd0;
            state_d     = IDLE;
            frame_cnt_d = (frame_cnt_q == 16'hFFFF) ? 16'h0001
                                                    : frame_cnt_q + 16'h0001;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    load         = can_load && emit;
    byte_valid_d = can_load ? emit : byte_valid_q;
    byte_data_d  = load ? ob   : byte_data_q;
    byte_sop_d   = load ? osop : byte_sop_q;
    byte_eop_d   = load ? oeop : byte_eop_q;
    pix_ready_d  = (state_d == PAYLOAD_IN);
  end

`ifdef CSI_PKT_CRC_EN
  logic crc_init, crc_en;
  assign crc_init = (state_d == LP_HDR) && (state_q != LP_HDR);
  assign crc_en   = load && (state_q == PAYLOAD_OUT);

  csi_crc16 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .data (ob),
    .crc  (crc)
  );
`else
  assign crc = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      b_cnt_q      <= 3'd0;
      g_cnt_q      <= 2'd0;
      pix_cnt_q    <= '0;
      frame_cnt_q  <= 16'h0001;
      eof_q        <= 1'b0;
      grp_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_sop_q   <= 1'b0;
      byte_eop_q   <= 1'b0;
      line_err_q   <= 1'b0;
      pix_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      b_cnt_q      <= b_cnt_d;
      g_cnt_q      <= g_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      eof_q        <= eof_d;
      grp_q        <= grp_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_sop_q   <= byte_sop_d;
      byte_eop_q   <= byte_eop_d;
      line_err_q   <= line_err_d;
      pix_ready_q  <= pix_ready_d;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_sop   = byte_sop_q;
  assign byte_eop   = byte_eop_q;
  assign line_err   = line_err_q;

endmodule

// File: tb/tb_csi_packet_builder.sv
// tb_csi_packet_builder: scoreboard bench for csi_packet_builder.
// Define CSI_PKT_CRC_EN to expect the computed CRC footer.
`timescale 1ns/1ps
module tb_csi_packet_builder;
  import csi_param_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [13:0] pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        pix_eol = 1'b0;
  logic        pix_eof = 1'b0;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic [7:0]  byte_data;
  logic        byte_sop;
  logic        byte_eop;
  logic        line_err;

  always #5 clk = ~clk;

  csi_packet_builder dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .pix_eof    (pix_eof),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_sop   (byte_sop),
    .byte_eop   (byte_eop),
    .line_err   (line_err)
  );

  logic [9:0]  exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          rx_cnt = 0;
  int          lerr_cnt = 0;
  bit          chk_en = 1'b1;
  bit          bp = 1'b0;
  bit          prev_stall = 1'b0;
  logic [9:0]  prev_out = '0;
  logic [13:0] px [16];
  logic [15:0] fcnt = 16'h0001;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    #1;
    byte_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every accepted byte.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(byte_valid), 32'd1);
        check("hold_data", 32'({byte_sop, byte_eop, byte_data}),
              32'(prev_out));
      end
      if (byte_valid && byte_ready) begin
        if (chk_en) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_byte: got 0x%0h, expected none",
                     {byte_sop, byte_eop, byte_data});
          end else begin
            check($sformatf("byte%0d{sop,eop,data}", rx_cnt),
                  32'({byte_sop, byte_eop, byte_data}),
                  32'(exp_q.pop_front()));
          end
        end
        rx_cnt++;
      end
      if (line_err) lerr_cnt++;
      prev_stall = byte_valid && !byte_ready;
      prev_out   = {byte_sop, byte_eop, byte_data};
    end
  end

  task automatic push(input logic [7:0] b, input bit s, input bit e);
    exp_q.push_back({s, e, b});
  endtask

  task automatic push_short(input logic [7:0] b0);
    push(b0, 1'b1, 1'b0);
    push(fcnt[7:0], 1'b0, 1'b0);
    push(fcnt[15:8], 1'b0, 1'b0);
    push(8'hCC, 1'b0, 1'b1);
  endtask

  task automatic push_line(input bit hand);
    logic [7:0]  kgrp [7] = '{8'hFF, 8'h00, 8'hAA, 8'h55, 8'h7F, 8'hA0, 8'h56};
    logic [7:0]  pl[$];
    logic [23:0] lsb;
    logic [15:0] crc;
    crc = 16'hFFFF;
    push(8'h2D, 1'b1, 1'b0);
    push(8'h1C, 1'b0, 1'b0);
    push(8'h00, 1'b0, 1'b0);
    push(8'hCC, 1'b0, 1'b0);
    for (int g = 0; g < 4; g++) begin
      if (hand) begin
        for (int k = 0; k < 7; k++) pl.push_back(kgrp[k]);
      end else begin
        for (int k = 0; k < 4; k++) pl.push_back(px[4*g+k][13:6]);
        lsb = {px[4*g+3][5:0], px[4*g+2][5:0], px[4*g+1][5:0], px[4*g][5:0]};
        pl.push_back(lsb[7:0]);
        pl.push_back(lsb[15:8]);
        pl.push_back(lsb[23:16]);
      end
    end
    foreach (pl[i]) begin
      push(pl[i], 1'b0, 1'b0);
      crc = csi_crc16_byte(crc, pl[i]);
    end
`ifdef CSI_PKT_CRC_EN
    push(crc[7:0], 1'b0, 1'b0);
    push(crc[15:8], 1'b0, 1'b1);
`else
    push(8'h00, 1'b0, 1'b0);
    push(8'h00, 1'b0, 1'b1);
`endif
  endtask

  task automatic send_pix(input logic [13:0] d, input bit sof, input bit eol,
                          input bit eof);
    int n;
    n = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    pix_eol   = eol;
    pix_eof   = eof;
    do begin
      @(negedge clk);
      n++;
    end while (!pix_ready && n < 400);
    if (!pix_ready) begin
      n_total++;
      $display("FAIL pix_timeout: pix_ready 0 after %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    pix_eof   = 1'b0;
  endtask

  task automatic send_line(input bit sof, input bit eof, input int eol_extra);
    for (int i = 0; i < 16; i++)
      send_pix(px[i], sof && i == 0, i == 15 || i == eol_extra,
               eof && i == 15);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d bytes outstanding, expected 0",
               exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input int lines, input bit hand, input int eol_extra);
    push_short(8'h00);
    for (int l = 0; l < lines; l++) push_line(hand);
    push_short(8'h01);
    fcnt = (fcnt == 16'hFFFF) ? 16'h0001 : fcnt + 16'h0001;
    for (int l = 0; l < lines; l++)
      send_line(l == 0, l == lines - 1, eol_extra);
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    int          r0;
    int          l0;
    int          n;
    logic [7:0]  kat [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                             8'h36, 8'h37, 8'h38, 8'h39};
    logic [15:0] c;

    repeat (3) @(negedge clk);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_data", 32'(byte_data), 32'd0);
    check("rst_byte_sop", 32'(byte_sop), 32'd0);
    check("rst_byte_eop", 32'(byte_eop), 32'd0);
    check("rst_line_err", 32'(line_err), 32'd0);
    check("rst_pix_ready", 32'(pix_ready), 32'd0);
    rst = 1'b0;

    c = 16'hFFFF;
    foreach (kat[i]) c = csi_crc16_byte(c, kat[i]);
    check("crc_kat_123456789", 32'(c), 32'h6F91);

    // Frame 1: ramp, single line
    for (int i = 0; i < 16; i++) px[i] = 14'(i);
    r0 = rx_cnt;
    l0 = lerr_cnt;
    run_frame(1, 1'b0, -1);
    check("frame1_byte_count", 32'(rx_cnt - r0), 32'd42);
    check("frame1_line_err", 32'(lerr_cnt - l0), 32'd0);

    // Frame 2: packing pattern with hand-computed payload
    for (int g = 0; g < 4; g++) begin
      px[4*g]   = 14'h3FFF;
      px[4*g+1] = 14'h0001;
      px[4*g+2] = 14'h2AAA;
      px[4*g+3] = 14'h1555;
    end
    run_frame(1, 1'b1, -1);

    // Frame 3: random backpressure
    for (int i = 0; i < 16; i++) px[i] = 14'((i * 733) ^ 14'h1234);
    bp = 1'b1;
    r0 = rx_cnt;
    run_frame(1, 1'b0, -1);
    bp = 1'b0;
    check("frame3_byte_count", 32'(rx_cnt - r0), 32'd42);

    // Frame 4: early eol on pixel 12
    for (int i = 0; i < 16; i++) px[i] = 14'(16'hC0DE - 16'(i * 97));
    r0 = rx_cnt;
    l0 = lerr_cnt;
    run_frame(1, 1'b0, 11);
    check("frame4_line_err_pulses", 32'(lerr_cnt - l0), 32'd1);
    check("frame4_byte_count", 32'(rx_cnt - r0), 32'd42);

    // Frame 5: two lines in one frame
    r0 = rx_cnt;
    run_frame(2, 1'b0, -1);
    check("frame5_byte_count", 32'(rx_cnt - r0), 32'd76);

    // Frame counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    fcnt = 16'hFFFF;
    run_frame(1, 1'b0, -1);
    run_frame(1, 1'b0, -1);

    // Reset in the middle of a payload
    chk_en    = 1'b0;
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    pix_data  = 14'h0123;
    n = 0;
    while (dut.state_q != PAYLOAD_OUT && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached_payload", 32'(dut.state_q), 32'(PAYLOAD_OUT));
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_byte_valid", 32'(byte_valid), 32'd0);
    check("midrst_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("midrst_pix_ready", 32'(pix_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_quiet", 32'(byte_valid), 32'd0);
    fcnt = 16'h0001;
    for (int i = 0; i < 16; i++) px[i] = 14'(14'h3FFF - 14'(i * 5));
    run_frame(1, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/csi_packet_builder.md
# csi_packet_builder

Packetizes the 14-bit image-sensor pixel stream into the CSI-2 byte stream: Frame Start short packet, one RAW14 long packet per line (header, packed payload, CRC footer), Frame End short packet. Sits between the image sensor model and the CSI FIFO / D-PHY lane serializer. Emits one byte per cycle with valid/ready handshakes on both sides, and marks packet boundaries so the lane layer can frame HS bursts.

## Interface
- LINE_PIXELS, 16: pixels per line; must be a multiple of 4.
- VC, 2'h0: virtual channel.
- DT, 6'h2D: long-packet data type (RAW14).
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
- pix_data  in  14  pixel value.
- pix_sof  in  1  first pixel of frame.
- pix_eol  in  1  last pixel of line.
- pix_eof  in  1  last pixel of frame; valid only together with pix_eol.
- byte_valid  out  1  output byte present.
- byte_ready  in  1  downstream accepts the byte.
- byte_data  out  8  output byte.
- byte_sop  out  1  first byte of a packet.
- byte_eop  out  1  last byte of a packet.
- line_err  out  1  one-cycle pulse on a pix_eol position mismatch.

## Operation
- Word count WC = LINE_PIXELS*7/4 (28 = 0x1C by default). ECC byte is the constant 8'hCC.
- FSM states: IDLE, FS, LP_HDR, PAYLOAD_IN, PAYLOAD_OUT, FOOTER, FE.
- IDLE:
  - pix_ready=0.
  - pix_valid && pix_sof moves to FS; the pixel is not consumed.
  - pix_valid without pix_sof moves to LP_HDR.
- FS: emits 4 bytes: {VC,FRAME_START_DATA_TYPE}, frame_cnt[7:0], frame_cnt[15:8], 8'hCC. Then moves to LP_HDR.
- LP_HDR: emits 4 bytes: {VC,DT}, WC[7:0], WC[15:8], 8'hCC.
- PAYLOAD_IN:
  - pix_ready=1; collects 4 pixels into the group buffer P1..P4.
  - The 4th acceptance moves to PAYLOAD_OUT.
- PAYLOAD_OUT: emits 7 bytes in this order:
  - P1[13:6], P2[13:6], P3[13:6], P4[13:6]
  - {P2[1:0],P1[5:0]}, {P3[3:0],P2[5:2]}, {P4[5:0],P3[5:4]}
  - Then returns to PAYLOAD_IN, or goes to FOOTER once pix_cnt == LINE_PIXELS.
- FOOTER: emits CRC[7:0] then CRC[15:8]. Then goes to FE if the last pixel carried pix_eof, else to IDLE.
- FE:
  - Emits 4 bytes as FS, but with FRAME_END_DATA_TYPE.
  - frame_cnt increments on the last FE byte; 0xFFFF wraps to 0x0001.
  - Then goes to IDLE.
- Line length:
  - Line end is set by pix_cnt only.
  - pix_eol asserted at a position other than pixel LINE_PIXELS, or missing at that pixel, pulses line_err in the acceptance cycle. Processing is otherwise unaffected.
- pix_sof seen outside IDLE is ignored.
- pix_eof without pix_eol is ignored.
- byte_sop is high on byte 0 of FS, LP_HDR and FE.
- byte_eop is high on the last byte of FS, FOOTER and FE.

## Timing
- Output register:
  - byte_data, byte_sop and byte_eop change only when !byte_valid || byte_ready.
  - byte_valid, once high, stays high with stable data until accepted.
- Latency: pix_valid && pix_sof seen in IDLE at cycle N gives byte_valid with the FS byte 0 at cycle N+1.
- Throughput, with byte_ready held high:
  - 1 byte/cycle.
  - Per group: 4 input cycles + 7 output cycles, no overlap.
- pix_ready is 0 in every state except PAYLOAD_IN.
- Reset values:
  - byte_valid=0, byte_data=0, byte_sop=0, byte_eop=0, line_err=0, pix_ready=0.
  - State IDLE, pix_cnt=0, frame_cnt=1, CRC=0xFFFF.
- Reset mid-packet: the packet is abandoned and nothing further is emitted.
- CRC:
  - Seed 0xFFFF on entry to LP_HDR.
  - Updated on every accepted payload byte; LSB-first, reflected polynomial 0x8408, no final XOR.

## Configuration
- CSI_PKT_CRC_EN defined: the footer carries the computed CRC-16.
- CSI_PKT_CRC_EN undefined:
  - The footer is 8'h00, 8'h00.
  - No CRC logic is instantiated.

## Structure
- Constants go in csi_param_pkg:
  - FRAME_START_DATA_TYPE, FRAME_END_DATA_TYPE, PIXEL14BITS_DATA_TYPE, ECC
  - LONG_PACKET_FOOTER_WIDTH_BYTES, SHORT_PACKET_WIDTH_BYTES
- Also in csi_param_pkg:
  - typedef enum csi_pkt_state_t for the FSM states.
  - function csi_crc16_byte(crc, byte), shared with the bench scoreboard.
- Sub-module csi_crc16: a registered byte-wide CRC with init/en inputs. It is instantiated only under CSI_PKT_CRC_EN.

## Test plan
- Single-line frame (LINE_PIXELS=16):
  - Stimulus: pixels 0..15, sof on the first pixel, eol+eof on the last.
  - Required byte stream:
    - FS: 00 01 00 CC
    - Header: 2D 1C 00 CC
    - 28 payload bytes
    - Footer: 2 bytes
    - FE: 01 01 00 CC
  - Total 42 bytes; sop/eop on packet boundaries.
- Packing: pixels 0x3FFF, 0x0001, 0x2AAA, 0x1555 → payload 0xFF 0x00 0xAA 0x55 0x7F 0xA0 0x56.
- Backpressure: byte_ready toggling randomly 50%.
  - Stream is identical to the no-stall case.
  - byte_data never changes while byte_valid && !byte_ready.
- Frame counter: 3 frames → FS counts 1, 2, 3. Forcing frame_cnt=0xFFFF → the next frame is 1.
- Line error: eol on pixel 12 of 16 → line_err pulses once; the packet is still 28 payload bytes.
- CRC:
  - With CSI_PKT_CRC_EN, the footer equals csi_crc16_byte folded over the payload.
  - Without it, the footer is 00 00.
  - Reset asserted mid-payload → byte_valid=0 next cycle, FSM in IDLE.
